// File: rtl/cpu64_obi_transmitter.sv
// OBI initiator for a 64-bit core: one-deep request hold register, in-order tag FIFO, registered
// responses. Define CPU64_OBI_TX_TIMEOUT_EN to build the response watchdog.
module cpu64_obi_transmitter #(
  parameter int unsigned ADDR_W      = 39,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MAX_OUT     = 2,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [7:0]        req_be_i,
  input  logic [63:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_we_o,
  output logic              rsp_err_o,
  output logic              obi_req_o,
  input  logic              obi_gnt_i,
  output logic [ADDR_W-1:0] obi_addr_o,
  output logic              obi_we_o,
  output logic [7:0]        obi_be_o,
  output logic [DATA_W-1:0] obi_wdata_o,
  input  logic              obi_rvalid_i,
  input  logic [DATA_W-1:0] obi_rdata_i,
  output logic              err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic              hold_valid_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic              hold_we_q;
  logic [7:0]        hold_be_q;
  logic [DATA_W-1:0] hold_wdata_q;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [MAX_OUT-1:0] tag_q;
  logic [PtrW-1:0]    wptr_q, rptr_q;

  logic              rsp_valid_q;
  logic              rsp_we_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic grant, accept, pop_rvalid, timeout, pop;
  logic unused_addr;

  // Upper address bits are deliberately dropped.
  assign unused_addr = ^req_addr_i;

  assign obi_req_o   = hold_valid_q && (cnt_q < CntW'(MAX_OUT));
  assign grant       = obi_req_o && obi_gnt_i;
  assign req_ready_o = !hold_valid_q || grant;
  assign accept      = req_valid_i && req_ready_o;
  assign pop_rvalid  = obi_rvalid_i && (cnt_q != '0);
  assign pop         = pop_rvalid || timeout;

  assign obi_addr_o  = hold_addr_q;
  assign obi_we_o    = hold_we_q;
  assign obi_be_o    = hold_be_q;
  assign obi_wdata_o = hold_wdata_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_we_o    = rsp_we_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!grant && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Fields only load on acceptance, so they stay stable until the grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
      hold_addr_q  <= req_addr_i[ADDR_W-1:0];
      hold_we_q    <= req_we_i;
      hold_be_q    <= req_be_i;
      hold_wdata_q <= req_wdata_i;
    end else if (grant) begin
      hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (grant) begin
        tag_q[wptr_q] <= hold_we_q;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= pop;
      if (pop_rvalid) begin
        rsp_rdata_q <= obi_rdata_i;
        rsp_we_q    <= tag_q[rptr_q];
      end else if (timeout) begin
        rsp_rdata_q <= '0;
        rsp_we_q    <= tag_q[rptr_q];
      end
    end
  end

`ifdef CPU64_OBI_TX_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

  logic [TmrW-1:0] timer_q;
  logic            err_q;
  logic            rsp_err_q;

  // Fires on the cycle the timer would reach TIMEOUT_CYC; retirement lands one cycle later.
  assign timeout = (cnt_q != '0) && !obi_rvalid_i && (timer_q == TmrW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if ((cnt_q == '0) || obi_rvalid_i || timeout) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
      rsp_err_q <= timeout;
    end
  end

  assign rsp_err_o = rsp_err_q;
  assign err_o     = err_q;
`else
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu64_obi_transmitter.sv
// Bench for cpu64_obi_transmitter: directed scenarios plus a randomized run against a queue model.
module tb_cpu64_obi_transmitter;

  localparam int unsigned ADDR_W  = 39;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MAX_OUT = 2;
`ifdef CPU64_OBI_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = 16;
`else
  localparam int unsigned TIMEOUT_CYC = 256;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [7:0]        req_be;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_we, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              obi_req, obi_gnt, obi_we;
  logic [ADDR_W-1:0] obi_addr;
  logic [7:0]        obi_be;
  logic [DATA_W-1:0] obi_wdata;
  logic              obi_rvalid;
  logic [DATA_W-1:0] obi_rdata;
  logic              err;

  int errors = 0;
  int checks = 0;

  cpu64_obi_transmitter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_OUT     (MAX_OUT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_be_i     (req_be),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_we_o     (rsp_we),
    .rsp_err_o    (rsp_err),
    .obi_req_o    (obi_req),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_o   (obi_addr),
    .obi_we_o     (obi_we),
    .obi_be_o     (obi_be),
    .obi_wdata_o  (obi_wdata),
    .obi_rvalid_i (obi_rvalid),
    .obi_rdata_i  (obi_rdata),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_be     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata  = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_addr = '1;
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (obi_req !== 1'b0) begin errors++; $display("FAIL reset_obi_req: got %b want 0", obi_req); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (obi_addr !== '0) begin errors++; $display("FAIL reset_obi_addr: got %h want 0", obi_addr); end
    checks++; if (obi_be !== '0) begin errors++; $display("FAIL reset_obi_be: got %h want 0", obi_be); end
    checks++; if (obi_wdata !== '0) begin errors++; $display("FAIL reset_obi_wdata: got %h want 0", obi_wdata); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
  endtask

  task automatic test_single_read();
    tick();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_be    = 8'hFF;
    req_addr  = 64'hABCD_E000_8000_1000;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    obi_gnt   = 1'b1;
    #1;
    checks++; if (obi_req !== 1'b1) begin errors++; $display("FAIL single_obi_req: got %b want 1", obi_req); end
    checks++; if (obi_addr !== 39'h80001000) begin errors++; $display("FAIL single_addr: got %h want 80001000", obi_addr); end
    checks++; if (obi_be !== 8'hFF) begin errors++; $display("FAIL single_be: got %h want ff", obi_be); end
    checks++; if (obi_we !== 1'b0) begin errors++; $display("FAIL single_we: got %b want 0", obi_we); end
    tick();
    obi_gnt = 1'b0;
    #1;
    checks++; if (obi_req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b want 0", obi_req); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    tick();
    obi_rvalid = 1'b1;
    obi_rdata  = 64'hDEADBEEF_CAFEF00D;
    tick();
    obi_rvalid = 1'b0;
    obi_rdata  = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL single_rdata: got %h want deadbeefcafef00d", rsp_rdata); end
    checks++; if (rsp_we !== 1'b0) begin errors++; $display("FAIL single_rsp_we: got %b want 0", rsp_we); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_pulse: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL single_rdata_hold: got %h want deadbeefcafef00d", rsp_rdata); end
  endtask

  task automatic test_grant_stall();
    tick();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 8'h0F;
    req_addr  = 64'h0000_0012_3456_7890;
    req_wdata = 64'h1122334455667788;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (obi_req !== 1'b1) begin errors++; $display("FAIL stall_req[%0d]: got %b want 1", i, obi_req); end
      checks++; if (obi_addr !== 39'h12_3456_7890) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 1234567890", i, obi_addr); end
      checks++; if ({obi_we, obi_be} !== 9'h10F) begin errors++; $display("FAIL stall_we_be[%0d]: got %h want 10f", i, {obi_we, obi_be}); end
      checks++; if (obi_wdata !== 64'h1122334455667788) begin errors++; $display("FAIL stall_wdata[%0d]: got %h want 1122334455667788", i, obi_wdata); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, req_ready); end
      tick();
    end
    obi_gnt = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_gnt: got %b want 1", req_ready); end
    tick();
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b1;
    obi_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    obi_rvalid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1) begin errors++; $display("FAIL stall_rsp: got valid=%b we=%b want 1 1", rsp_valid, rsp_we); end
  endtask

  task automatic test_outstanding_limit();
    logic [63:0] a [3];
    logic [63:0] d [3];
    for (int i = 0; i < 3; i++) begin
      a[i] = {$urandom, $urandom};
      d[i] = {$urandom, $urandom};
    end
    tick();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a[0];
    obi_gnt   = 1'b1;
    #1;
    checks++; if (obi_req !== 1'b0) begin errors++; $display("FAIL lim_req_empty: got %b want 0", obi_req); end
    tick();
    req_addr = a[1];
    #1;
    checks++; if (obi_req !== 1'b1 || obi_addr !== a[0][ADDR_W-1:0]) begin errors++; $display("FAIL lim_issue0: got req=%b addr=%h want 1 %h", obi_req, obi_addr, a[0][ADDR_W-1:0]); end
    tick();
    req_addr = a[2];
    #1;
    checks++; if (obi_req !== 1'b1 || obi_addr !== a[1][ADDR_W-1:0]) begin errors++; $display("FAIL lim_issue1: got req=%b addr=%h want 1 %h", obi_req, obi_addr, a[1][ADDR_W-1:0]); end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (obi_req !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL lim_block[%0d]: got req=%b ready=%b want 0 0", i, obi_req, req_ready); end
      tick();
    end
    obi_rvalid = 1'b1;
    obi_rdata  = d[0];
    tick();
    obi_rdata = d[1];
    #1;
    checks++; if (obi_req !== 1'b1 || obi_addr !== a[2][ADDR_W-1:0]) begin errors++; $display("FAIL lim_issue2: got req=%b addr=%h want 1 %h", obi_req, obi_addr, a[2][ADDR_W-1:0]); end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== d[0]) begin errors++; $display("FAIL lim_rsp0: got %b %h want 1 %h", rsp_valid, rsp_rdata, d[0]); end
    tick();
    obi_rdata = d[2];
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== d[1]) begin errors++; $display("FAIL lim_rsp1: got %b %h want 1 %h", rsp_valid, rsp_rdata, d[1]); end
    checks++; if (obi_req !== 1'b0) begin errors++; $display("FAIL lim_idle: got %b want 0", obi_req); end
    tick();
    idle();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== d[2]) begin errors++; $display("FAIL lim_rsp2: got %b %h want 1 %h", rsp_valid, rsp_rdata, d[2]); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lim_done: got %b want 0", rsp_valid); end
  endtask

  task automatic test_simultaneous();
    tick();
    req_valid = 1'b1;
    req_we    = 1'b0;
    obi_gnt   = 1'b1;
    tick();
    req_we = 1'b1;
    tick();
    req_valid  = 1'b0;
    obi_rvalid = 1'b1;
    obi_rdata  = 64'hA5A5_0000_1111_2222;
    #1;
    checks++; if (obi_req !== 1'b1) begin errors++; $display("FAIL simul_req: got %b want 1", obi_req); end
    tick();
    idle();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 64'hA5A5_0000_1111_2222) begin
      errors++; $display("FAIL simul_rsp0: got %b %b %h want 1 0 a5a5000011112222", rsp_valid, rsp_we, rsp_rdata);
    end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL simul_gap: got %b want 0", rsp_valid); end
    obi_rvalid = 1'b1;
    obi_rdata  = 64'h5A5A_3333_4444_5555;
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 64'h5A5A_3333_4444_5555) begin
      errors++; $display("FAIL simul_rsp1: got %b %b %h want 1 1 5a5a333344445555", rsp_valid, rsp_we, rsp_rdata);
    end
    tick();
    obi_rvalid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL simul_cnt_empty: got %b want 0", rsp_valid); end
  endtask

  task automatic test_spurious_and_reset();
    tick();
    idle();
    obi_rvalid = 1'b1;
    obi_rdata  = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL spurious[%0d]: got %b want 0", i, rsp_valid); end
    end
    obi_rvalid = 1'b0;
    req_valid  = 1'b1;
    req_be     = 8'h3C;
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
    obi_gnt    = 1'b1;
    tick();
    tick();
    tick();
    idle();
    #1;
    checks++; if (obi_req !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL full_before_reset: got req=%b ready=%b want 0 0", obi_req, req_ready); end
    rst_n = 1'b0;
    tick();
    checks++; if (obi_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b %b want 0 1", obi_req, req_ready); end
    checks++; if ({obi_addr, obi_be, obi_wdata} !== '0) begin errors++; $display("FAIL rst_fields: got %h %h %h want 0", obi_addr, obi_be, obi_wdata); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || err !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b %h %b want 0 0 0", rsp_valid, rsp_rdata, err); end
    rst_n = 1'b1;
    obi_rvalid = 1'b1;
    tick();
    obi_rvalid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rvalid_after_rst: got %b want 0", rsp_valid); end
  endtask

  task automatic test_random();
    bit          hold_v = 1'b0;
    logic [63:0] h_addr, h_wdata;
    logic        h_we;
    logic [7:0]  h_be;
    bit          outq[$];
    bit          exp_v = 1'b0;
    bit          exp_we = 1'b0;
    logic [63:0] exp_data = '0;
    bit          exp_req, exp_ready, drain;
    int          quiet = 0;
    for (int i = 0; i < 520; i++) begin
      tick();
      drain      = (i >= 500);
      req_valid  = !drain && ($urandom_range(0, 2) != 0);
      req_we     = 1'($urandom);
      req_be     = 8'($urandom);
      req_addr   = {$urandom, $urandom};
      req_wdata  = {$urandom, $urandom};
      obi_gnt    = drain || ($urandom_range(0, 3) != 0);
      obi_rvalid = drain || (quiet >= 8) || ($urandom_range(0, 2) == 0);
      obi_rdata  = {$urandom, $urandom};
      #1;
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", i, rsp_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rsp_rdata !== exp_data || rsp_we !== exp_we) begin
          errors++; $display("FAIL rnd_rsp@%0d: got %h we=%b want %h we=%b", i, rsp_rdata, rsp_we, exp_data, exp_we);
        end
      end
      exp_req   = hold_v && (outq.size() < MAX_OUT);
      exp_ready = !hold_v || (exp_req && obi_gnt);
      checks++; if (obi_req !== exp_req || req_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_hs@%0d: got req=%b ready=%b want %b %b", i, obi_req, req_ready, exp_req, exp_ready);
      end
      if (exp_req) begin
        checks++; if (obi_addr !== h_addr[ADDR_W-1:0] || obi_we !== h_we || obi_be !== h_be || obi_wdata !== h_wdata) begin
          errors++; $display("FAIL rnd_fields@%0d: got %h %b %h %h want %h %b %h %h", i, obi_addr, obi_we, obi_be, obi_wdata,
                             h_addr[ADDR_W-1:0], h_we, h_be, h_wdata);
        end
      end
      exp_v = 1'b0;
      if (obi_rvalid && outq.size() > 0) begin
        exp_v    = 1'b1;
        exp_we   = outq.pop_front();
        exp_data = obi_rdata;
      end
      if (exp_req && obi_gnt) begin
        outq.push_back(h_we);
        hold_v = 1'b0;
      end
      if (req_valid && exp_ready) begin
        hold_v  = 1'b1;
        h_addr  = req_addr;
        h_we    = req_we;
        h_be    = req_be;
        h_wdata = req_wdata;
      end
      quiet = (obi_rvalid || outq.size() == 0) ? 0 : quiet + 1;
    end
    tick();
    idle();
    #1;
    checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rnd_tail: got %b want %b", rsp_valid, exp_v); end
    tick();
  endtask

`ifdef CPU64_OBI_TX_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    idle();
    req_valid = 1'b1;
    req_addr  = {$urandom, $urandom};
    obi_gnt   = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    obi_gnt = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (rsp_valid !== (k == 16) || err !== (k == 16)) begin
        errors++; $display("FAIL tmo_cycle%0d: got valid=%b err=%b want %b", k, rsp_valid, err, (k == 16));
      end
      if (k == 16) begin
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== '0 || rsp_we !== 1'b0) begin
          errors++; $display("FAIL tmo_rsp: got err=%b rdata=%h we=%b want 1 0 0", rsp_err, rsp_rdata, rsp_we);
        end
      end
    end
    obi_rvalid = 1'b1;
    tick();
    obi_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_after: got %b %b want 0 0", rsp_valid, rsp_err); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got valid=%b err=%b want 0 1", rsp_valid, err); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_grant_stall();
    test_outstanding_limit();
    test_simultaneous();
    test_spurious_and_reset();
    test_random();
`ifdef CPU64_OBI_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
